// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetcher feeding the decoder.
//   Issues one word request at a time to the memory controller, presents each
//   returned instruction with its pc and a taken/not-taken prediction, and
//   redirects on decoder (JAL/JALR) or ROB flush. Conditional branches are
//   predicted by a direct-mapped table of 2-bit saturating counters trained
//   by the ROB.
// Ports:
//   clk_in, rst_in (async, active low), rdy_in (global freeze when low)
//   mem_req_valid/mem_req_addr     : one-cycle fetch request pulse
//   mem_resp_valid/mem_resp_data   : one response per request
//   ins_ready/ins/pc/pred_jump     : instruction presented to the decoder
//   IFetcher_stall/clear/new_addr  : decoder back-pressure and redirect
//   rob_clear/rob_new_pc           : ROB mispredict flush (highest priority)
//   bp_update_valid/pc/taken       : branch-outcome training strobe
module ifetch_unit #(
    parameter int unsigned BHT_BITS = 6,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        ins_ready,
    output logic [31:0] ins,
    output logic [31:0] pc,
    output logic        pred_jump,
    input  logic        IFetcher_stall,
    input  logic        IFetcher_clear,
    input  logic [31:0] IFetcher_new_addr,
    input  logic        rob_clear,
    input  logic [31:0] rob_new_pc,
    input  logic        bp_update_valid,
    input  logic [31:0] bp_update_pc,
    input  logic        bp_update_taken
);

    localparam int unsigned BHT_ENTRIES = 1 << BHT_BITS;
    localparam logic [6:0]  OP_BRANCH   = 7'b1100011;
    localparam logic [6:0]  OP_JAL      = 7'b1101111;
    localparam logic [6:0]  OP_JALR     = 7'b1100111;

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_PRESENT,
        S_HOLD_JUMP,
        S_DISCARD
    } state_t;

    state_t      state, state_d;
    logic [31:0] fetch_pc, fetch_pc_d;
    logic        req_valid_d;
    logic [31:0] req_addr_d;
    logic        ins_ready_d;
    logic [31:0] ins_d;
    logic [31:0] pc_d;
    logic        pred_jump_d;

    logic [1:0]          bht [BHT_ENTRIES];
    logic [BHT_BITS-1:0] lookup_idx;
    logic [BHT_BITS-1:0] update_idx;

    logic        redirect;
    logic [31:0] redirect_pc;
    logic [6:0]  opcode;
    logic [31:0] imm_b;
    logic        unused_bp_bits;

    assign redirect    = rob_clear | IFetcher_clear;
    assign redirect_pc = rob_clear ? rob_new_pc : IFetcher_new_addr;
    assign opcode      = ins[6:0];
    assign imm_b       = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign lookup_idx  = fetch_pc[BHT_BITS+1:2];
    assign update_idx  = bp_update_pc[BHT_BITS+1:2];
    assign unused_bp_bits = ^{bp_update_pc[31:BHT_BITS+2], bp_update_pc[1:0]};

    always_comb begin
        state_d     = state;
        fetch_pc_d  = fetch_pc;
        req_valid_d = 1'b0;
        req_addr_d  = mem_req_addr;
        ins_ready_d = ins_ready;
        ins_d       = ins;
        pc_d        = pc;
        pred_jump_d = pred_jump;

        // A redirect always retargets and withdraws any presented instruction;
        // the per-state code below only decides where the FSM goes.
        if (redirect) begin
            fetch_pc_d  = redirect_pc;
            ins_ready_d = 1'b0;
        end

        case (state)
            S_REQ: begin
                if (!redirect) begin
                    req_valid_d = 1'b1;
                    req_addr_d  = fetch_pc;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    // A response landing with the redirect is the outstanding
                    // one, so it is dropped here rather than in DISCARD.
                    state_d = mem_resp_valid ? S_REQ : S_DISCARD;
                end else if (mem_resp_valid) begin
                    ins_d       = mem_resp_data;
                    pc_d        = fetch_pc;
                    ins_ready_d = 1'b1;
                    pred_jump_d = (mem_resp_data[6:0] == OP_BRANCH) && bht[lookup_idx][1];
                    state_d     = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (redirect) begin
                    state_d = S_REQ;
                end else if (!IFetcher_stall) begin
                    ins_ready_d = 1'b0;
                    case (opcode)
                        OP_BRANCH: begin
                            fetch_pc_d = pred_jump ? (pc + imm_b) : (pc + 32'd4);
                            state_d    = S_REQ;
                        end
                        OP_JAL, OP_JALR: state_d = S_HOLD_JUMP;
                        default: begin
                            fetch_pc_d = pc + 32'd4;
                            state_d    = S_REQ;
                        end
                    endcase
                end
            end
            S_HOLD_JUMP: begin
                if (redirect) state_d = S_REQ;
            end
            S_DISCARD: begin
                if (mem_resp_valid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state         <= S_REQ;
            fetch_pc      <= RESET_PC;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            ins_ready     <= 1'b0;
            ins           <= '0;
            pc            <= '1;
            pred_jump     <= 1'b0;
        end else if (rdy_in) begin
            state         <= state_d;
            fetch_pc      <= fetch_pc_d;
            mem_req_valid <= req_valid_d;
            mem_req_addr  <= req_addr_d;
            ins_ready     <= ins_ready_d;
            ins           <= ins_d;
            pc            <= pc_d;
            pred_jump     <= pred_jump_d;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (rdy_in && bp_update_valid) begin
            if (bp_update_taken) begin
                if (bht[update_idx] != 2'b11) bht[update_idx] <= bht[update_idx] + 2'd1;
            end else begin
                if (bht[update_idx] != 2'b00) bht[update_idx] <= bht[update_idx] - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed self-checking bench for ifetch_unit.
//   A small memory model answers requests after a programmable latency
//   (or is bypassed for hand-driven responses); each test task drives one
//   scenario and compares outputs at the falling clock edge.
`timescale 1ns/1ps
module tb_ifetch_unit;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        ins_ready;
    logic [31:0] ins;
    logic [31:0] pc;
    logic        pred_jump;
    logic        IFetcher_stall = 1'b0;
    logic        IFetcher_clear = 1'b0;
    logic [31:0] IFetcher_new_addr = '0;
    logic        rob_clear = 1'b0;
    logic [31:0] rob_new_pc = '0;
    logic        bp_update_valid = 1'b0;
    logic [31:0] bp_update_pc = '0;
    logic        bp_update_taken = 1'b0;

    int total = 0;
    int bad   = 0;

    // memory model
    logic [31:0] imem [256];
    logic        mem_auto = 1'b1;
    int unsigned lat = 1;
    logic        model_valid = 1'b0;
    logic [31:0] model_data = '0;
    logic        man_valid = 1'b0;
    logic [31:0] man_data = '0;
    int unsigned m_cnt = 0;
    logic [31:0] m_addr = '0;

    assign mem_resp_valid = mem_auto ? model_valid : man_valid;
    assign mem_resp_data  = mem_auto ? model_data  : man_data;

    always #5 clk_in = ~clk_in;

    ifetch_unit #(.BHT_BITS(6), .RESET_PC(32'h0)) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .rdy_in            (rdy_in),
        .mem_req_valid     (mem_req_valid),
        .mem_req_addr      (mem_req_addr),
        .mem_resp_valid    (mem_resp_valid),
        .mem_resp_data     (mem_resp_data),
        .ins_ready         (ins_ready),
        .ins               (ins),
        .pc                (pc),
        .pred_jump         (pred_jump),
        .IFetcher_stall    (IFetcher_stall),
        .IFetcher_clear    (IFetcher_clear),
        .IFetcher_new_addr (IFetcher_new_addr),
        .rob_clear         (rob_clear),
        .rob_new_pc        (rob_new_pc),
        .bp_update_valid   (bp_update_valid),
        .bp_update_pc      (bp_update_pc),
        .bp_update_taken   (bp_update_taken)
    );

    // Sees each request pulse just after the edge that raised it and answers
    // 'lat' steps later with a one-cycle strobe.
    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            if (mem_auto && rst_in) begin
                model_valid = 1'b0;
                if (m_cnt > 0) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        model_valid = 1'b1;
                        model_data  = imem[m_addr[9:2]];
                    end
                end
                if (mem_req_valid) begin
                    m_addr = mem_req_addr;
                    m_cnt  = lat;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_req(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk_in);
            if (mem_req_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_ins(input int max, output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk_in);
            if (ins_ready === 1'b1) begin
                ok  = 1'b1;
                cyc = i;
                break;
            end
        end
    endtask

    task automatic rob_redirect(input logic [31:0] target);
        rob_clear  = 1'b1;
        rob_new_pc = target;
        @(negedge clk_in);
        rob_clear  = 1'b0;
    endtask

    task automatic bp_pulse(input logic [31:0] bpc, input logic taken);
        bp_update_valid = 1'b1;
        bp_update_pc    = bpc;
        bp_update_taken = taken;
        @(negedge clk_in);
        bp_update_valid = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk_in);
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%b exp=0", mem_req_valid); end
        total++; if (mem_req_addr !== 32'h0) begin bad++; $display("FAIL rst_req_addr got=%h exp=00000000", mem_req_addr); end
        total++; if (ins_ready !== 1'b0) begin bad++; $display("FAIL rst_ins_ready got=%b exp=0", ins_ready); end
        total++; if (ins !== 32'h0) begin bad++; $display("FAIL rst_ins got=%h exp=00000000", ins); end
        total++; if (pc !== 32'hffffffff) begin bad++; $display("FAIL rst_pc got=%h exp=ffffffff", pc); end
        total++; if (pred_jump !== 1'b0) begin bad++; $display("FAIL rst_pred got=%b exp=0", pred_jump); end
        rst_in = 1'b1;
    endtask

    task automatic test_sequential;
        bit ok;
        int cyc;
        @(negedge clk_in);
        total++; if (mem_req_valid !== 1'b1) begin bad++; $display("FAIL seq_first_req got=%b exp=1", mem_req_valid); end
        total++; if (mem_req_addr !== 32'h0) begin bad++; $display("FAIL seq_addr0 got=%h exp=00000000", mem_req_addr); end
        wait_ins(8, ok, cyc);
        total++; if (!ok) begin bad++; $display("FAIL seq_ins0_timeout got=none exp=ins_ready"); end
        total++; if (cyc != 2) begin bad++; $display("FAIL seq_latency got=%0d exp=2", cyc); end
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL seq_pc0 got=%h exp=00000000", pc); end
        total++; if (ins !== 32'h00000013) begin bad++; $display("FAIL seq_ins0 got=%h exp=00000013", ins); end
        total++; if (pred_jump !== 1'b0) begin bad++; $display("FAIL seq_pred0 got=%b exp=0", pred_jump); end
        for (int k = 1; k <= 2; k++) begin
            logic [31:0] exp_pc;
            exp_pc = 32'(k * 4);
            wait_req(6, ok);
            total++; if (!ok || mem_req_addr !== exp_pc) begin bad++; $display("FAIL seq_req_addr got=%h exp=%h", mem_req_addr, exp_pc); end
            wait_ins(6, ok, cyc);
            total++; if (!ok || pc !== exp_pc) begin bad++; $display("FAIL seq_pc got=%h exp=%h", pc, exp_pc); end
            total++; if (pred_jump !== 1'b0) begin bad++; $display("FAIL seq_pred got=%b exp=0", pred_jump); end
        end
    endtask

    task automatic test_branch;
        bit ok;
        int cyc;
        // counter at 0x20: 01 -> 10 -> 11 -> 11 (third must saturate)
        bp_pulse(32'h20, 1'b1);
        bp_pulse(32'h20, 1'b1);
        bp_pulse(32'h20, 1'b1);
        rob_redirect(32'h20);
        wait_req(8, ok);
        total++; if (!ok || mem_req_addr !== 32'h20) begin bad++; $display("FAIL br_req got=%h exp=00000020", mem_req_addr); end
        wait_ins(8, ok, cyc);
        total++; if (!ok || pc !== 32'h20) begin bad++; $display("FAIL br_pc got=%h exp=00000020", pc); end
        total++; if (ins !== 32'hfe000ee3) begin bad++; $display("FAIL br_ins got=%h exp=fe000ee3", ins); end
        total++; if (pred_jump !== 1'b1) begin bad++; $display("FAIL br_pred_taken got=%b exp=1", pred_jump); end
        wait_req(6, ok);
        total++; if (!ok || mem_req_addr !== 32'h1c) begin bad++; $display("FAIL br_target got=%h exp=0000001c", mem_req_addr); end
        // untrained entry at 0x60
        rob_redirect(32'h60);
        wait_ins(10, ok, cyc);
        total++; if (!ok || pc !== 32'h60) begin bad++; $display("FAIL br_untr_pc got=%h exp=00000060", pc); end
        total++; if (pred_jump !== 1'b0) begin bad++; $display("FAIL br_untr_pred got=%b exp=0", pred_jump); end
        wait_req(6, ok);
        total++; if (!ok || mem_req_addr !== 32'h64) begin bad++; $display("FAIL br_untr_next got=%h exp=00000064", mem_req_addr); end
        // 11 -> 10 -> 01 -> 00 -> 00 (fourth must saturate)
        for (int k = 0; k < 4; k++) bp_pulse(32'h20, 1'b0);
        rob_redirect(32'h20);
        wait_ins(10, ok, cyc);
        total++; if (!ok || pc !== 32'h20) begin bad++; $display("FAIL br_sat_pc got=%h exp=00000020", pc); end
        total++; if (pred_jump !== 1'b0) begin bad++; $display("FAIL br_sat_pred got=%b exp=0", pred_jump); end
        wait_req(6, ok);
        total++; if (!ok || mem_req_addr !== 32'h24) begin bad++; $display("FAIL br_sat_next got=%h exp=00000024", mem_req_addr); end
    endtask

    task automatic test_stall;
        bit ok;
        int cyc;
        IFetcher_stall = 1'b1;
        rob_redirect(32'h10);
        wait_ins(10, ok, cyc);
        total++; if (!ok || pc !== 32'h10) begin bad++; $display("FAIL st_pc got=%h exp=00000010", pc); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_in);
            total++; if (ins_ready !== 1'b1) begin bad++; $display("FAIL st_hold_ready cyc=%0d got=%b exp=1", k, ins_ready); end
            total++; if (pc !== 32'h10) begin bad++; $display("FAIL st_hold_pc cyc=%0d got=%h exp=00000010", k, pc); end
            total++; if (ins !== 32'h00000013) begin bad++; $display("FAIL st_hold_ins cyc=%0d got=%h exp=00000013", k, ins); end
            total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL st_no_req cyc=%0d got=%b exp=0", k, mem_req_valid); end
        end
        IFetcher_stall = 1'b0;
        @(negedge clk_in);
        total++; if (ins_ready !== 1'b0) begin bad++; $display("FAIL st_accept got=%b exp=0", ins_ready); end
        @(negedge clk_in);
        total++; if (mem_req_valid !== 1'b1) begin bad++; $display("FAIL st_req_after got=%b exp=1", mem_req_valid); end
        total++; if (mem_req_addr !== 32'h14) begin bad++; $display("FAIL st_req_addr got=%h exp=00000014", mem_req_addr); end
    endtask

    task automatic test_jump;
        bit ok;
        bit seen;
        int cyc;
        rob_redirect(32'h40);
        wait_ins(10, ok, cyc);
        total++; if (!ok || ins !== 32'h0000006f) begin bad++; $display("FAIL jal_ins got=%h exp=0000006f", ins); end
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            if (mem_req_valid !== 1'b0 || ins_ready !== 1'b0) seen = 1'b1;
        end
        total++; if (seen) begin bad++; $display("FAIL jal_hold got=activity exp=idle"); end
        IFetcher_clear     = 1'b1;
        IFetcher_new_addr  = 32'h100;
        @(negedge clk_in);
        IFetcher_clear     = 1'b0;
        wait_req(4, ok);
        total++; if (!ok || mem_req_addr !== 32'h100) begin bad++; $display("FAIL jal_target got=%h exp=00000100", mem_req_addr); end
        wait_ins(6, ok, cyc);
        total++; if (!ok || ins !== 32'h00008067) begin bad++; $display("FAIL jalr_ins got=%h exp=00008067", ins); end
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            if (mem_req_valid !== 1'b0) seen = 1'b1;
        end
        total++; if (seen) begin bad++; $display("FAIL jalr_hold got=request exp=none"); end
        rob_redirect(32'h180);
        wait_req(4, ok);
        total++; if (!ok || mem_req_addr !== 32'h180) begin bad++; $display("FAIL jalr_target got=%h exp=00000180", mem_req_addr); end
    endtask

    task automatic test_rob_clear;
        bit ok;
        bit seen;
        int cyc;
        lat = 3;
        rob_redirect(32'h80);
        wait_req(12, ok);
        total++; if (!ok || mem_req_addr !== 32'h80) begin bad++; $display("FAIL rob_req80 got=%h exp=00000080", mem_req_addr); end
        rob_clear  = 1'b1;
        rob_new_pc = 32'h200;
        lat        = 1;
        @(negedge clk_in);
        rob_clear  = 1'b0;
        seen = 1'b0;
        ok   = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_in);
            if (ins_ready === 1'b1) seen = 1'b1;
            if (mem_req_valid === 1'b1) begin ok = 1'b1; break; end
        end
        total++; if (seen) begin bad++; $display("FAIL rob_drop got=ins_ready exp=none"); end
        total++; if (!ok || mem_req_addr !== 32'h200) begin bad++; $display("FAIL rob_req200 got=%h exp=00000200", mem_req_addr); end
        wait_ins(6, ok, cyc);
        total++; if (!ok || pc !== 32'h200) begin bad++; $display("FAIL rob_pc200 got=%h exp=00000200", pc); end
        // both redirects together: ROB target wins
        rob_clear         = 1'b1;
        rob_new_pc        = 32'h240;
        IFetcher_clear    = 1'b1;
        IFetcher_new_addr = 32'h300;
        @(negedge clk_in);
        rob_clear         = 1'b0;
        IFetcher_clear    = 1'b0;
        total++; if (ins_ready !== 1'b0) begin bad++; $display("FAIL prio_ready got=%b exp=0", ins_ready); end
        wait_req(4, ok);
        total++; if (!ok || mem_req_addr !== 32'h240) begin bad++; $display("FAIL prio_addr got=%h exp=00000240", mem_req_addr); end
        // redirect on the same edge as the response: no DISCARD detour
        @(negedge clk_in);
        rob_clear  = 1'b1;
        rob_new_pc = 32'h2c0;
        @(negedge clk_in);
        rob_clear  = 1'b0;
        total++; if (ins_ready !== 1'b0 || mem_req_valid !== 1'b0) begin bad++; $display("FAIL same_edge_idle got=%b%b exp=00", ins_ready, mem_req_valid); end
        @(negedge clk_in);
        total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h2c0) begin bad++; $display("FAIL same_edge_req got=%b/%h exp=1/000002c0", mem_req_valid, mem_req_addr); end
    endtask

    task automatic test_rdy_reset;
        bit ok;
        int cyc;
        IFetcher_stall = 1'b1;
        rob_redirect(32'hc0);
        wait_ins(10, ok, cyc);
        total++; if (!ok || pc !== 32'hc0) begin bad++; $display("FAIL rdy_setup_pc got=%h exp=000000c0", pc); end
        mem_auto       = 1'b0;
        man_valid      = 1'b0;
        rob_clear      = 1'b1;
        rob_new_pc     = 32'h30;
        IFetcher_stall = 1'b0;
        @(negedge clk_in);
        rob_clear      = 1'b0;
        wait_req(4, ok);
        total++; if (!ok || mem_req_addr !== 32'h30) begin bad++; $display("FAIL rdy_req got=%h exp=00000030", mem_req_addr); end
        @(negedge clk_in);
        rdy_in          = 1'b0;
        man_valid       = 1'b1;
        man_data        = 32'hfe000ee3;
        bp_update_valid = 1'b1;
        bp_update_pc    = 32'h30;
        bp_update_taken = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            total++; if (ins_ready !== 1'b0) begin bad++; $display("FAIL rdy_frozen_ready cyc=%0d got=%b exp=0", k, ins_ready); end
            total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL rdy_frozen_req cyc=%0d got=%b exp=0", k, mem_req_valid); end
        end
        rdy_in          = 1'b1;
        bp_update_valid = 1'b0;
        @(negedge clk_in);
        man_valid = 1'b0;
        total++; if (ins_ready !== 1'b1 || pc !== 32'h30) begin bad++; $display("FAIL rdy_resume got=%b/%h exp=1/00000030", ins_ready, pc); end
        total++; if (pred_jump !== 1'b0) begin bad++; $display("FAIL rdy_bht_frozen got=%b exp=0", pred_jump); end
        wait_req(4, ok);
        total++; if (!ok || mem_req_addr !== 32'h34) begin bad++; $display("FAIL rdy_next got=%h exp=00000034", mem_req_addr); end
        @(negedge clk_in);
        #2;
        rst_in = 1'b0;
        #1;
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL arst_req_valid got=%b exp=0", mem_req_valid); end
        total++; if (mem_req_addr !== 32'h0) begin bad++; $display("FAIL arst_req_addr got=%h exp=00000000", mem_req_addr); end
        total++; if (ins_ready !== 1'b0) begin bad++; $display("FAIL arst_ready got=%b exp=0", ins_ready); end
        total++; if (ins !== 32'h0) begin bad++; $display("FAIL arst_ins got=%h exp=00000000", ins); end
        total++; if (pc !== 32'hffffffff) begin bad++; $display("FAIL arst_pc got=%h exp=ffffffff", pc); end
        total++; if (pred_jump !== 1'b0) begin bad++; $display("FAIL arst_pred got=%b exp=0", pred_jump); end
        @(negedge clk_in);
        mem_auto = 1'b1;
        rst_in   = 1'b1;
        @(negedge clk_in);
        total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0) begin bad++; $display("FAIL arst_restart got=%b/%h exp=1/00000000", mem_req_valid, mem_req_addr); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 32'h00000013;
        imem[32'h20 >> 2]  = 32'hfe000ee3;
        imem[32'h60 >> 2]  = 32'hfe000ee3;
        imem[32'h40 >> 2]  = 32'h0000006f;
        imem[32'h100 >> 2] = 32'h00008067;
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_jump();
        test_rob_clear();
        test_rdy_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
